// File: rtl/rx_word_pkg.sv
// rx_word_pkg: shared encodings, default COM symbol and word-length helper for rx_word_assembler.
package rx_word_pkg;
    localparam logic [1:0] DS_8 = 2'b00;
    localparam logic [1:0] DS_16 = 2'b01;
    localparam logic [1:0] DS_32 = 2'b10;
    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;
    typedef enum logic {UNALIGNED = 1'b0, ALIGNED = 1'b1} alignState_t;
    function automatic logic [2:0] wordLen(input logic [1:0] ds);
        return ds == DS_16 ? 3'd2 : ds == DS_32 ? 3'd4 : 3'd1;
    endfunction
endpackage

// File: rtl/rx_word_assembler_align_fsm.sv
// rx_align_fsm: alignment state, consecutive-invalid counter and COM detection for rx_word_assembler.
module rx_align_fsm
    import rx_word_pkg::*;
#(
    parameter logic [7:0] COM_SYM = COM_SYM_DEFAULT,
    parameter int LOSS_THRESH = 4
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] dataIn,
    input  logic       kIn,
    input  logic       invalidIn,
    input  logic       partial,
    output logic       aligned,
    output logic       comDet,
    output logic       realign,
    output logic       drop,
    output logic       store
);
    alignState_t state, stateNxt;
    logic [3:0] invCnt, invCntNxt;
    always_ff @(posedge clkRx) begin
        if (rst) begin
            state <= UNALIGNED;
            invCnt <= '0;
        end else begin
            state <= stateNxt;
            invCnt <= invCntNxt;
        end
    end
    // drop fires on the symbol that brings the invalid run up to LOSS_THRESH
    always_comb begin
        aligned = state == ALIGNED;
        comDet = enb && kIn && !invalidIn && dataIn == COM_SYM;
        drop = enb && aligned && invalidIn && invCnt == 4'(LOSS_THRESH - 1);
        realign = aligned && comDet && partial;
        store = aligned ? enb && !drop : comDet;
        stateNxt = drop ? UNALIGNED : comDet ? ALIGNED : state;
        invCntNxt = drop ? 4'd0 : (enb && aligned) ? (invalidIn ? invCnt + 4'd1 : 4'd0) : invCnt;
    end
endmodule

// File: rtl/rx_word_assembler.sv
// rx_word_assembler: COM-aligned 8/16/32-bit word reassembly from decoded symbols.
// Defining RX_PWRCNT_EN enables the saturating output-toggle counter on pwrCnt.
module rx_word_assembler
    import rx_word_pkg::*;
#(
    parameter logic [7:0] COM_SYM = COM_SYM_DEFAULT,
    parameter int LOSS_THRESH = 4
) (
    input  logic        clkRx,
    input  logic        rst,
    input  logic        enb,
    input  logic [1:0]  dataS,
    input  logic [7:0]  dataIn,
    input  logic        k_in,
    input  logic        invalid_in,
    output logic [7:0]  dataOut8,
    output logic [15:0] dataOut16,
    output logic [31:0] dataOut32,
    output logic [3:0]  kMask,
    output logic        valid,
    output logic        aligned,
    output logic        err,
    output logic [31:0] pwrCnt
);
    logic comDet, realign, drop, store, dsChg, partial, complete, wordErr, errBuf;
    logic [1:0] dsEff, dsReg, idx, effIdx;
    logic [2:0] n;
    logic [31:0] wordNxt, wordBuf, out32Nxt;
    logic [15:0] out16Nxt;
    logic [7:0] out8Nxt;
    logic [3:0] kNxt, kBuf, kMaskNxt;
    logic validNxt, errNxt;

    rx_align_fsm #(.COM_SYM(COM_SYM), .LOSS_THRESH(LOSS_THRESH)) uFsm (
        .clkRx(clkRx),
        .rst(rst),
        .enb(enb),
        .dataIn(dataIn),
        .kIn(k_in),
        .invalidIn(invalid_in),
        .partial(partial),
        .aligned(aligned),
        .comDet(comDet),
        .realign(realign),
        .drop(drop),
        .store(store)
    );

    // A width change or any COM restarts the word, so the symbol lands in byte 0
    always_comb begin
        dsEff = dataS == 2'b11 ? DS_8 : dataS;
        n = wordLen(dsEff);
        dsChg = enb && dsEff != dsReg;
        partial = idx != 2'd0 && !dsChg;
        effIdx = (comDet || dsChg) ? 2'd0 : idx;
        wordNxt = (effIdx == 2'd0 ? 32'd0 : wordBuf) | (32'(invalid_in ? 8'h00 : dataIn) << {effIdx, 3'b000});
        kNxt = (effIdx == 2'd0 ? 4'd0 : kBuf) | (4'(k_in && !invalid_in) << effIdx);
        wordErr = (effIdx != 2'd0 && errBuf) || invalid_in;
        complete = store && {1'b0, effIdx} == n - 3'd1;
        validNxt = complete;
        errNxt = (complete && wordErr) || realign;
        out8Nxt = (complete && n == 3'd1) ? wordNxt[7:0] : dataOut8;
        out16Nxt = (complete && n == 3'd2) ? wordNxt[15:0] : dataOut16;
        out32Nxt = (complete && n == 3'd4) ? wordNxt : dataOut32;
        kMaskNxt = complete ? kNxt : kMask;
    end

    always_ff @(posedge clkRx) begin
        if (rst) begin
            dsReg <= DS_8;
            idx <= 2'd0;
            wordBuf <= '0;
            kBuf <= '0;
            errBuf <= 1'b0;
            dataOut8 <= '0;
            dataOut16 <= '0;
            dataOut32 <= '0;
            kMask <= '0;
            valid <= 1'b0;
            err <= 1'b0;
        end else begin
            if (enb) begin
                dsReg <= dsEff;
                idx <= (store && !complete) ? effIdx + 2'd1 : 2'd0;
            end
            if (store) begin
                wordBuf <= wordNxt;
                kBuf <= kNxt;
                errBuf <= wordErr;
            end
            dataOut8 <= out8Nxt;
            dataOut16 <= out16Nxt;
            dataOut32 <= out32Nxt;
            kMask <= kMaskNxt;
            valid <= validNxt;
            err <= errNxt;
        end
    end

`ifdef RX_PWRCNT_EN
    logic [32:0] pwrSum;
    always_comb pwrSum = {1'b0, pwrCnt} + 33'($countones({dataOut8, dataOut16, dataOut32, kMask, valid} ^ {out8Nxt, out16Nxt, out32Nxt, kMaskNxt, validNxt}));
    always_ff @(posedge clkRx) pwrCnt <= rst ? 32'd0 : pwrSum[32] ? 32'hFFFF_FFFF : pwrSum[31:0];
`else
    assign pwrCnt = 32'd0;
`endif
endmodule

// File: tb/tb_rx_word_assembler.sv
// tb_rx_word_assembler: directed vector table plus randomized stream against a queue-based reference model.
module tb_rx_word_assembler;
    localparam int LOSS = 4;
`ifdef RX_PWRCNT_EN
    localparam bit PWR_EN = 1'b1;
`else
    localparam bit PWR_EN = 1'b0;
`endif
    logic clkRx = 1'b0;
    logic rst, enb, k_in, invalid_in;
    logic [1:0] dataS;
    logic [7:0] dataIn, dataOut8;
    logic [15:0] dataOut16;
    logic [31:0] dataOut32, pwrCnt;
    logic [3:0] kMask;
    logic valid, aligned, err;

    always #5 clkRx = ~clkRx;

    rx_word_assembler #(.COM_SYM(8'hBC), .LOSS_THRESH(LOSS)) dut (
        .clkRx(clkRx),
        .rst(rst),
        .enb(enb),
        .dataS(dataS),
        .dataIn(dataIn),
        .k_in(k_in),
        .invalid_in(invalid_in),
        .dataOut8(dataOut8),
        .dataOut16(dataOut16),
        .dataOut32(dataOut32),
        .kMask(kMask),
        .valid(valid),
        .aligned(aligned),
        .err(err),
        .pwrCnt(pwrCnt)
    );

    typedef struct {
        logic r; logic e; logic [1:0] s; logic [7:0] d; logic k; logic i;
        logic v; logic er; logic al; logic [31:0] w; logic [3:0] km;
    } vec_t;
    vec_t tbl[$];
    int checkCnt = 0;
    int passCnt = 0;

    logic [7:0] q[$];
    bit kq[$];
    bit acc, mAl, mV, mE;
    int cnt, mN;
    logic [7:0] m8;
    logic [15:0] m16;
    logic [31:0] m32;
    logic [3:0] mK;
    longint mPwr;

    function automatic vec_t mk(logic r, logic e, logic [1:0] s, logic [7:0] d, logic k, logic i,
                                logic v, logic er, logic al, logic [31:0] w, logic [3:0] km);
        vec_t x;
        x.r = r; x.e = e; x.s = s; x.d = d; x.k = k; x.i = i;
        x.v = v; x.er = er; x.al = al; x.w = w; x.km = km;
        return x;
    endfunction

    function automatic logic [31:0] selOut(input logic [1:0] s);
        return s == 2'b01 ? 32'(dataOut16) : s == 2'b10 ? dataOut32 : 32'(dataOut8);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic clearWord();
        q.delete();
        kq.delete();
        acc = 0;
    endtask

    task automatic modelStep(input logic r, e, input logic [1:0] s, input logic [7:0] d, input logic k, inv);
        logic [60:0] pv, nv;
        logic [31:0] w;
        logic [3:0] km;
        int n;
        bit isCom;
        if (r) begin
            m8 = 0; m16 = 0; m32 = 0; mK = 0; mV = 0; mE = 0; mAl = 0;
            clearWord();
            cnt = 0; mN = 1; mPwr = 0;
            return;
        end
        pv = {m8, m16, m32, mK, mV};
        mV = 0;
        mE = 0;
        if (e) begin
            n = s == 2'b01 ? 2 : s == 2'b10 ? 4 : 1;
            if (n != mN) clearWord();
            mN = n;
            isCom = k && d == 8'hBC && !inv;
            if (!mAl) begin
                if (isCom) begin
                    mAl = 1;
                    q.push_back(8'hBC);
                    kq.push_back(1'b1);
                end
            end else if (isCom) begin
                if (q.size() != 0) mE = 1;
                clearWord();
                cnt = 0;
                q.push_back(8'hBC);
                kq.push_back(1'b1);
            end else if (inv) begin
                cnt++;
                if (cnt == LOSS) begin
                    mAl = 0;
                    cnt = 0;
                    clearWord();
                end else begin
                    q.push_back(8'h00);
                    kq.push_back(1'b0);
                    acc = 1;
                end
            end else begin
                cnt = 0;
                q.push_back(d);
                kq.push_back(k);
            end
            if (mAl && q.size() == n) begin
                w = 0;
                km = 0;
                foreach (q[j]) begin
                    w = w | (32'(q[j]) << (8 * j));
                    km[j] = kq[j];
                end
                mV = 1;
                mE = mE | acc;
                mK = km;
                if (n == 1) m8 = w[7:0];
                else if (n == 2) m16 = w[15:0];
                else m32 = w;
                clearWord();
            end
        end
        nv = {m8, m16, m32, mK, mV};
        mPwr = mPwr + $countones(pv ^ nv);
        if (mPwr > 64'hFFFF_FFFF) mPwr = 64'hFFFF_FFFF;
    endtask

    task automatic step(input logic r, e, input logic [1:0] s, input logic [7:0] d, input logic k, i);
        rst = r; enb = e; dataS = s; dataIn = d; k_in = k; invalid_in = i;
        @(posedge clkRx);
        #1;
        modelStep(r, e, s, d, k, i);
        chk("model_valid", 32'(valid), 32'(mV));
        chk("model_err", 32'(err), 32'(mE));
        chk("model_aligned", 32'(aligned), 32'(mAl));
        chk("model_dataOut8", 32'(dataOut8), 32'(m8));
        chk("model_dataOut16", 32'(dataOut16), 32'(m16));
        chk("model_dataOut32", dataOut32, m32);
        chk("model_kMask", 32'(kMask), 32'(mK));
        chk("model_pwrCnt", pwrCnt, PWR_EN ? 32'(mPwr) : 32'd0);
    endtask

    initial begin
        bit mode;
        logic r, e, k, i;
        logic [1:0] s;
        logic [7:0] d;
        // reset, then 8-bit stream
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 0, 8'hBC, 1, 0, 1, 0, 1, 32'hBC, 4'h1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 32'h00, 4'h0));
        tbl.push_back(mk(0, 1, 0, 8'hCC, 0, 0, 1, 0, 1, 32'hCC, 4'h0));
        tbl.push_back(mk(0, 1, 0, 8'hAB, 0, 0, 1, 0, 1, 32'hAB, 4'h0));
        tbl.push_back(mk(0, 1, 0, 8'h25, 0, 0, 1, 0, 1, 32'h25, 4'h0));
        // 16-bit
        tbl.push_back(mk(0, 1, 1, 8'hBC, 1, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 32'h00BC, 4'h1));
        tbl.push_back(mk(0, 1, 1, 8'hCD, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'hAB, 0, 0, 1, 0, 1, 32'hABCD, 4'h0));
        // 32-bit with an enb gap
        tbl.push_back(mk(0, 1, 2, 8'hBC, 1, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h6F, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h45, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 0, 2, 8'hE7, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h23, 0, 0, 1, 0, 1, 32'h2345_6FBC, 4'h1));
        tbl.push_back(mk(0, 1, 2, 8'h01, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        // COM at index 2 realigns
        tbl.push_back(mk(0, 1, 2, 8'h02, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'hBC, 1, 0, 0, 1, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h11, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h22, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h33, 0, 0, 1, 0, 1, 32'h3322_11BC, 4'h1));
        // invalid byte completes a word with err; dataS=11 acts as 8-bit
        tbl.push_back(mk(0, 1, 0, 8'h77, 1, 1, 1, 1, 1, 32'h00, 4'h0));
        tbl.push_back(mk(0, 1, 0, 8'h99, 0, 0, 1, 0, 1, 32'h99, 4'h0));
        tbl.push_back(mk(0, 1, 3, 8'h5A, 0, 0, 1, 0, 1, 32'h5A, 4'h0));
        // loss of alignment after LOSS invalids, then realign
        tbl.push_back(mk(0, 1, 2, 8'hFF, 0, 1, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'hFF, 0, 1, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'hFF, 0, 1, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'hFF, 0, 1, 0, 0, 0, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h55, 0, 0, 0, 0, 0, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h66, 0, 0, 0, 0, 0, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'hBC, 1, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h01, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h02, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h03, 0, 0, 1, 0, 1, 32'h0302_01BC, 4'h1));
        // reset mid-word
        tbl.push_back(mk(0, 1, 2, 8'hBC, 1, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h01, 0, 0, 0, 0, 1, 32'h0, 4'h0));
        tbl.push_back(mk(1, 1, 2, 8'h02, 0, 0, 0, 0, 0, 32'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 8'h03, 0, 0, 0, 0, 0, 32'h0, 4'h0));
        foreach (tbl[n]) begin
            step(tbl[n].r, tbl[n].e, tbl[n].s, tbl[n].d, tbl[n].k, tbl[n].i);
            chk($sformatf("tbl%0d_valid", n), 32'(valid), 32'(tbl[n].v));
            chk($sformatf("tbl%0d_err", n), 32'(err), 32'(tbl[n].er));
            chk($sformatf("tbl%0d_aligned", n), 32'(aligned), 32'(tbl[n].al));
            if (tbl[n].v || tbl[n].r) begin
                chk($sformatf("tbl%0d_word", n), selOut(tbl[n].s), tbl[n].w);
                chk($sformatf("tbl%0d_kMask", n), 32'(kMask), 32'(tbl[n].km));
            end
        end
        // randomized stream with bursts of invalid symbols
        mode = 0;
        s = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) mode = !mode;
            r = $urandom_range(0, 499) == 0;
            e = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 29) == 0) s = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 4) == 0;
            d = (k && $urandom_range(0, 1) == 1) ? 8'hBC : 8'($urandom);
            i = mode ? $urandom_range(0, 3) != 0 : $urandom_range(0, 24) == 0;
            step(r, e, s, d, k, i);
        end
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
Receive-side width adapter; the counterpart of the transmit-side width/serial path.
- Takes the decoded 8-bit symbol stream from the recibidor (byte, K flag, invalid flag), one symbol per clkRx cycle.
- Aligns on the COM symbol and reassembles 8/16/32-bit words as selected by dataS.
- Output mirrors the dataIn8/dataIn16/dataIn32 the transmitter was fed.

Parameters:
COM_SYM, 8'hBC, K-symbol value (K28.5) used for word alignment
LOSS_THRESH, 4, consecutive invalid symbols that drop alignment (range 1..15)

Ports:
clkRx  input  1  receive clock; all logic on posedge
rst  input  1  synchronous, active-high reset
enb  input  1  symbol valid/enable; symbol consumed only when 1
dataS  input  2  width select: 00=8, 01=16, 10=32, 11 treated as 00
dataIn  input  8  decoded symbol from recibidor
k_in  input  1  symbol is a K code
invalid_in  input  1  symbol failed decode
dataOut8  output  8  assembled 8-bit word
dataOut16  output  16  assembled 16-bit word
dataOut32  output  32  assembled 32-bit word
kMask  output  4  bit i = byte i of last word was a K symbol (unused bits 0)
valid  output  1  one-cycle strobe, new word on selected output
aligned  output  1  FSM in ALIGNED
err  output  1  one-cycle strobe, word contained an invalid symbol or realign occurred
pwrCnt  output  32  output toggle count (see Optional Feature)

Behaviour:
- Clocking and reset: single clock clkRx; reset synchronous, active-high.
- rst=1 at posedge: all outputs 0, state UNALIGNED, byte index 0, invalid counter 0, partial word cleared. Applies mid-word and discards the partial word.
- Only cycles with enb=1 consume a symbol. With enb=0, all state holds and valid/err are 0.
- UNALIGNED:
  - Symbols are discarded.
  - A symbol with k_in=1, dataIn==COM_SYM and invalid_in=0 moves to ALIGNED.
  - That COM becomes byte 0 of the first word; index becomes 1, or the word completes immediately in 8-bit mode.
- ALIGNED:
  - Byte i is stored at bits [8i+7:8i]; the first byte goes to the LSB.
  - Word length N = 1/2/4 per dataS.
  - When index reaches N-1, the word completes.
- Latency: the word-completing symbol is sampled at edge t. At edge t, the selected dataOutX, kMask and valid=1 register, so they are visible in cycle t+1.
- Outputs: only the selected width output updates; the others hold. valid is high for exactly one cycle per word.
- COM in ALIGNED at index≠0:
  - The partial word is dropped.
  - COM restarts as byte 0.
  - err pulses for one cycle in the same cycle.
- COM at index 0 is normal data (byte 0, kMask bit set).
- invalid_in=1 in ALIGNED:
  - The byte is stored as 8'h00.
  - The word still completes, with err=1 in the same cycle as valid.
  - The consecutive-invalid counter increments; any valid symbol clears it.
  - When the counter reaches LOSS_THRESH: go to UNALIGNED, drop the partial word, aligned=0 next cycle, and no valid for that symbol.
- dataS change:
  - A change is detected against a registered copy, sampled only on consumed cycles.
  - The partial word is dropped and the index resets to 0.
  - The new width applies to the current symbol.
  - No err pulse.
- Simultaneous COM-realign and invalid are impossible, because a COM must have invalid_in=0.

Optional Feature:
- Macro: RX_PWRCNT_EN.
- Defined: pwrCnt increments by the number of bits that toggled in {dataOut8, dataOut16, dataOut32, kMask, valid} per cycle. It saturates at 32'hFFFFFFFF and clears on rst.
- Undefined: counter logic is omitted and pwrCnt is tied to 0.

Decomposition:
- Package rx_word_pkg:
  - dataS encodings (DS_8=2'b00, DS_16=2'b01, DS_32=2'b10)
  - default COM_SYM
  - FSM state encoding (UNALIGNED=0, ALIGNED=1)
  - word length function N(dataS)
- One sub-module, rx_align_fsm: holds the alignment state, the invalid counter and the COM detection. It outputs aligned, realign and drop strobes.
- The top level holds the byte shifter, output registers and the optional counter.

Test Plan:
- Reset, then enb=1, dataS=00, stream {BC(K), 00, CC, AB, 25} -> aligned=1 after the first cycle; dataOut8 = BC, 00, CC, AB, 25 on consecutive cycles; kMask=0001 only on BC; valid high each cycle.
- dataS=01, stream {BC(K), 00, CD, AB} -> dataOut16=16'h00BC with kMask=0001, then 16'hABCD with kMask=0000; valid every 2nd consumed symbol.
- dataS=10, stream {BC(K), 6F, 45, 23, 01} with enb=0 inserted between 45 and 23 -> first word 32'h2345_6FBC valid once; the enb gap does not corrupt it; 01 starts the next word.
- In ALIGNED at dataS=10 with index=2, send BC(K) -> err pulse, partial word dropped; next 3 bytes 11,22,33 -> dataOut32=32'h332211BC.
- Four consecutive invalid_in=1 symbols with LOSS_THRESH=4 -> aligned falls after the 4th; subsequent data (no COM) gives no valid; BC(K) realigns.
- rst asserted mid 32-bit word -> all outputs 0 next cycle, aligned=0; with RX_PWRCNT_EN defined, pwrCnt=0 after reset and equals the toggle count of the prior scenario otherwise.
